// File: rtl/divide_unit.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | divide_unit : iterative radix-2 restoring divider for RV32M DIV/REM ops |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module divide_unit #(
  parameter int XLEN    = 32,
  parameter int COUNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [1:0]      FUNCT3,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  input  logic [4:0]      DEST_ADDRESS,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            VALID,
  output logic [XLEN-1:0] RESULT,
  output logic [4:0]      RESULT_ADDRESS
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     divisor_q, divisor_d;
  logic                qsign_q, qsign_d;
  logic                rsign_q, rsign_d;
  logic                is_rem_q, is_rem_d;
  logic [4:0]          dest_q, dest_d;
  logic                valid_q, valid_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [4:0]          result_addr_q, result_addr_d;

  logic            is_signed, sign1, sign2, div_zero, overflow, rem_ge;
  logic [XLEN-1:0] mag1, mag2;
  logic [XLEN:0]   rem_shift, rem_diff;

  assign is_signed = ~FUNCT3[0];
  assign sign1     = is_signed & OPERAND1[XLEN-1];
  assign sign2     = is_signed & OPERAND2[XLEN-1];
  assign mag1      = sign1 ? -OPERAND1 : OPERAND1;
  assign mag2      = sign2 ? -OPERAND2 : OPERAND2;
  assign div_zero  = (OPERAND2 == '0);
  assign overflow  = is_signed && (OPERAND1 == {1'b1, {(XLEN-1){1'b0}}}) && (OPERAND2 == '1);

  // The shifted partial remainder is one bit wider; the difference's top bit is the borrow.
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, divisor_q};
  assign rem_ge    = ~rem_diff[XLEN];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    quo_d         = quo_q;
    rem_d         = rem_q;
    divisor_d     = divisor_q;
    qsign_d       = qsign_q;
    rsign_d       = rsign_q;
    is_rem_d      = is_rem_q;
    dest_d        = dest_q;
    valid_d       = 1'b0;
    result_d      = result_q;
    result_addr_d = result_addr_q;

    case (state_q)
      IDLE: begin
        if (START) begin
          is_rem_d = FUNCT3[1];
          dest_d   = DEST_ADDRESS;
          cnt_d    = '0;
          if (div_zero) begin
            // Final values are preloaded so FIX resolves the special case unchanged.
            quo_d   = '1;
            rem_d   = OPERAND1;
            qsign_d = 1'b0;
            rsign_d = 1'b0;
            state_d = FIX;
          end else if (overflow) begin
            quo_d   = OPERAND1;
            rem_d   = '0;
            qsign_d = 1'b0;
            rsign_d = 1'b0;
            state_d = FIX;
          end else begin
            quo_d     = mag1;
            rem_d     = '0;
            divisor_d = mag2;
            qsign_d   = sign1 ^ sign2;
            rsign_d   = sign1;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (FLUSH) begin
          state_d = IDLE;
        end else begin
          quo_d = {quo_q[XLEN-2:0], rem_ge};
          rem_d = rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
          if (cnt_q == COUNT_W'(XLEN-1)) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q + COUNT_W'(1);
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!FLUSH) begin
          if (is_rem_q) result_d = rsign_q ? -rem_q : rem_q;
          else          result_d = qsign_q ? -quo_q : quo_q;
          result_addr_d = dest_q;
          valid_d       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      divisor_q     <= '0;
      qsign_q       <= 1'b0;
      rsign_q       <= 1'b0;
      is_rem_q      <= 1'b0;
      dest_q        <= '0;
      valid_q       <= 1'b0;
      result_q      <= '0;
      result_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      quo_q         <= quo_d;
      rem_q         <= rem_d;
      divisor_q     <= divisor_d;
      qsign_q       <= qsign_d;
      rsign_q       <= rsign_d;
      is_rem_q      <= is_rem_d;
      dest_q        <= dest_d;
      valid_q       <= valid_d;
      result_q      <= result_d;
      result_addr_q <= result_addr_d;
    end
  end

  assign BUSY           = (state_q != IDLE);
  assign VALID          = valid_q;
  assign RESULT         = result_q;
  assign RESULT_ADDRESS = result_addr_q;

endmodule
`default_nettype wire
